// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch responder
//
// Purpose: default widths, the NOP word substituted for misaligned fetches,
// the queue entry layout and small helpers used by ifetch_responder.
// Ports: none (package).

package ifetch_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;

  localparam logic [DATA_W_DEF-1:0] NOP_INST = 32'h0000_0000;

  // One queued fetch result. Field widths follow the package defaults, so the
  // top-level ADDR_W/DATA_W parameters are expected to stay at those values.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] inst;
    logic [ADDR_W_DEF-1:0] pc;
    logic                  misalign;
  } fetch_entry_t;

  // Instructions are word aligned; any low address bit set is a fault.
  function automatic logic is_misaligned(input logic [ADDR_W_DEF-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // A misaligned fetch never reads memory, so its entry carries a NOP
  // instead of whatever happens to be on the read-data bus.
  function automatic fetch_entry_t make_entry(input logic [DATA_W_DEF-1:0] rdata,
                                              input logic [ADDR_W_DEF-1:0] pc,
                                              input logic                  misalign);
    fetch_entry_t e;
    e.inst     = misalign ? NOP_INST : rdata;
    e.pc       = pc;
    e.misalign = misalign;
    return e;
  endfunction

endpackage

// File: rtl/ifetch_responder_sync_fifo.sv
// rtl/ifetch_responder_sync_fifo.sv - synchronous FIFO holding fetch results
//
// Purpose: power-of-two deep register FIFO with push/pop/count and no bypass;
// a pushed word becomes visible on pop_data the cycle after the push.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clr             synchronous clear (flush), lower priority than rst
//   push, push_data write one entry
//   pop             consume the head entry (ignored when empty)
//   pop_data        head entry, all zeros while empty
//   count           number of stored entries, 0..DEPTH

module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; an empty queue masks it on the output instead.
  always_ff @(posedge clk) begin
    if (!rst && !clr && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Upstream credit accounting must keep a full queue from being pushed
  // unless the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      assert (!(do_push && full && !do_pop))
        else $error("sync_fifo: push into full queue");
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/ifetch_responder.sv
// rtl/ifetch_responder.sv - fetch request to tagged instruction responder
//
// Purpose: accepts fetch addresses from the PC stage, issues reads to a
// synchronous instruction memory (data one cycle after the enable), and
// queues each returned word with its PC for the IF/ID register. Credits
// cover both queued and in-flight reads so decode stalls never drop data.
// A flush discards everything queued or in flight.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_addr        fetch request from the PC stage
//   req_ready                 request accepted when req_valid && req_ready
//   flush                     discard queued and in-flight fetches
//   imem_en/imem_addr         instruction memory read port
//   imem_rdata                read data, one cycle after imem_en
//   inst_valid/inst_ready     head handshake toward IF/ID
//   inst/inst_pc/inst_misalign head entry contents

module ifetch_responder
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_misalign
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             inflight;
  logic [ADDR_W-1:0] pend_pc;
  logic             pend_misalign;
  logic             accept;
  logic             req_misalign;
  logic             push;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Every accepted fetch owns a queue slot from acceptance onward, so the
  // read in flight counts against the credit alongside the stored entries.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign req_ready = !rst && !flush && (occupancy < (CNT_W+1)'(DEPTH));

  assign accept       = req_valid && req_ready;
  assign req_misalign = is_misaligned(req_addr);

  // Misaligned fetches skip the memory access entirely.
  assign imem_en   = accept && !req_misalign;
  assign imem_addr = req_addr;

  // Tracks the single outstanding read and the tag it will be queued with.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight      <= 1'b0;
      pend_pc       <= '0;
      pend_misalign <= 1'b0;
    end else if (flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        pend_pc       <= req_addr;
        pend_misalign <= req_misalign;
      end
    end
  end

  // The read data arrives while inflight is set; a flush in that cycle
  // drops it, reset drops it inside the queue.
  assign push       = inflight && !flush;
  assign push_entry = make_entry(imem_rdata, pend_pc, pend_misalign);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (inst_ready),
    .pop_data  (head_entry),
    .count     (count)
  );

  assign inst_valid    = (count != '0);
  assign inst          = head_entry.inst;
  assign inst_pc       = head_entry.pc;
  assign inst_misalign = head_entry.misalign;

endmodule

// File: tb/tb_ifetch_responder.sv
// tb/tb_ifetch_responder.sv - self-checking bench for ifetch_responder

module tb_ifetch_responder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_misalign;

  ifetch_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .flush         (flush),
    .imem_en       (imem_en),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_misalign (inst_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        rv;
    logic [31:0] addr;
    logic        ir;
    logic        er;
    logic        een;
    logic [31:0] ea;
    logic        ev;
    logic [31:0] einst;
    logic [31:0] epc;
    logic        emis;
    logic        chk0;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  int n_cmp;
  int n_bad;

  // Reference model: queue of expected entries plus one pending read.
  ent_t        q[$];
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        prev_rst;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_0003;
      32'h8:   return 32'h0109_5020;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic rv,
                              input logic [31:0] addr, input logic ir,
                              input logic er, input logic een, input logic [31:0] ea,
                              input logic ev, input logic [31:0] einst,
                              input logic [31:0] epc, input logic emis, input logic chk0);
    vec_t v;
    v.rst = r; v.flush = f; v.rv = rv; v.addr = addr; v.ir = ir;
    v.er = er; v.een = een; v.ea = ea; v.ev = ev;
    v.einst = einst; v.epc = epc; v.emis = emis; v.chk0 = chk0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, act, req);
    end
  endtask

  // One clock cycle: inputs are already driven; check at the falling edge,
  // advance the model, then return read data for any read issued this cycle.
  task automatic step(input logic use_tbl, input vec_t row);
    vec_t        m;
    vec_t        x;
    ent_t        e;
    int          occ;
    logic        seen_en;
    logic [31:0] seen_addr;
    @(negedge clk);
    occ   = q.size() + (pend_v ? 1 : 0);
    m     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m.er  = !rst && !flush && (occ < DEPTH);
    m.een = m.er && req_valid && (req_addr[1:0] == 2'b00);
    m.ea  = req_addr;
    m.ev  = (q.size() != 0);
    if (m.ev) begin
      m.einst = q[0].inst;
      m.epc   = q[0].pc;
      m.emis  = q[0].mis;
    end
    m.chk0 = prev_rst;
    x = use_tbl ? row : m;

    chk("req_ready", {31'b0, req_ready}, {31'b0, x.er});
    chk("imem_en", {31'b0, imem_en}, {31'b0, x.een});
    if (x.een) chk("imem_addr", imem_addr, x.ea);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, x.ev});
    if (x.ev || x.chk0) begin
      chk("inst", inst, x.einst);
      chk("inst_pc", inst_pc, x.epc);
      chk("inst_misalign", {31'b0, inst_misalign}, {31'b0, x.emis});
    end

    seen_en   = imem_en;
    seen_addr = imem_addr;

    prev_rst = rst;
    if (rst || flush) begin
      q.delete();
      pend_v = 1'b0;
    end else begin
      if (m.ev && inst_ready) void'(q.pop_front());
      if (pend_v) begin
        e.pc   = pend_addr;
        e.mis  = (pend_addr[1:0] != 2'b00);
        e.inst = e.mis ? 32'h0 : mem_fn(pend_addr);
        q.push_back(e);
      end
      pend_v    = m.er && req_valid;
      pend_addr = req_addr;
    end

    @(posedge clk);
    #1;
    imem_rdata = seen_en ? mem_fn(seen_addr) : $urandom();
  endtask

  vec_t tbl[$];

  initial begin
    vec_t dummy;
    int   ir_pct;
    n_cmp = 0; n_bad = 0;
    pend_v = 1'b0; pend_addr = '0; prev_rst = 1'b1;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_addr = '0;
    inst_ready = 1'b0; imem_rdata = '0;
    dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // rst flush rv addr ir | req_ready imem_en imem_addr inst_valid inst pc mis chk0
    tbl.push_back(mk(1,0,0,32'h0 ,0, 0,0,32'h0 , 0,32'h0,32'h0,0,1));
    // sequential stream
    tbl.push_back(mk(0,0,1,32'h0 ,1, 1,1,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h4 ,1, 1,1,32'h4 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h8 ,1, 1,1,32'h8 , 1,32'h2008_0005,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,32'h2009_0003,32'h4,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,32'h0109_5020,32'h8,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    // back-pressure: four accepts then full, head held
    tbl.push_back(mk(0,0,1,32'h0 ,0, 1,1,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h4 ,0, 1,1,32'h4 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h8 ,0, 1,1,32'h8 , 1,mem_fn(32'h0),32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'hC ,0, 1,1,32'hC , 1,mem_fn(32'h0),32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h10,0, 0,0,32'h0 , 1,mem_fn(32'h0),32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h10,0, 0,0,32'h0 , 1,mem_fn(32'h0),32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h10,1, 0,0,32'h0 , 1,mem_fn(32'h0),32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h10,1, 1,1,32'h10, 1,mem_fn(32'h4),32'h4,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,mem_fn(32'h8),32'h8,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,mem_fn(32'hC),32'hC,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,mem_fn(32'h10),32'h10,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    // flush with a read in flight
    tbl.push_back(mk(0,0,1,32'h10,1, 1,1,32'h10, 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,1,1,32'h14,1, 0,0,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h40,1, 1,1,32'h40, 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,mem_fn(32'h40),32'h40,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    // misaligned fetch
    tbl.push_back(mk(0,0,1,32'h6 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,32'h0,32'h6,1,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    // reset with three entries queued
    tbl.push_back(mk(0,0,1,32'h20,0, 1,1,32'h20, 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h24,0, 1,1,32'h24, 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,1,32'h28,0, 1,1,32'h28, 1,mem_fn(32'h20),32'h20,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 1,0,32'h0 , 1,mem_fn(32'h20),32'h20,0,0));
    tbl.push_back(mk(1,0,0,32'h0 ,0, 0,0,32'h0 , 1,mem_fn(32'h20),32'h20,0,0));
    tbl.push_back(mk(0,0,1,32'h0 ,1, 1,1,32'h0 , 0,32'h0,32'h0,0,1));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 1,mem_fn(32'h0),32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    // flush while the head is being popped
    tbl.push_back(mk(0,0,1,32'h8 ,0, 1,1,32'h8 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,0, 1,0,32'h0 , 0,32'h0,32'h0,0,0));
    tbl.push_back(mk(0,1,0,32'h0 ,1, 0,0,32'h0 , 1,mem_fn(32'h8),32'h8,0,0));
    tbl.push_back(mk(0,0,0,32'h0 ,1, 1,0,32'h0 , 0,32'h0,32'h0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst        = tbl[i].rst;
      flush      = tbl[i].flush;
      req_valid  = tbl[i].rv;
      req_addr   = tbl[i].addr;
      inst_ready = tbl[i].ir;
      step(1'b1, tbl[i]);
    end

    // Randomized traffic against the queue model, with phases of varying
    // decode back-pressure so the queue runs empty, partly full and full.
    ir_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       ir_pct = 100;
          1:       ir_pct = 70;
          2:       ir_pct = 30;
          default: ir_pct = 5;
        endcase
      end
      rst        = ($urandom_range(0, 99) < 2);
      flush      = ($urandom_range(0, 99) < 5);
      req_valid  = ($urandom_range(0, 99) < 80);
      inst_ready = ($urandom_range(0, 99) < ir_pct);
      if ($urandom_range(0, 9) == 0)
        req_addr = ($urandom_range(0, 4095) << 2) | $urandom_range(1, 3);
      else
        req_addr = $urandom_range(0, 4095) << 2;
      step(1'b0, dummy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_responder.md
Name: ifetch_responder

Overview:
Consumes fetch addresses from the PC stage and reads the synchronous instruction memory. It returns each instruction, tagged with its PC, to the IF/ID pipeline register over a valid/ready handshake. An internal queue absorbs decode stalls without losing in-flight reads. A flush input discards all queued and in-flight fetches on a taken branch or jump.

Parameters:
ADDR_W, 32, fetch address width in bits (byte address)
DATA_W, 32, instruction width in bits
DEPTH, 4, response queue entries (power of two, >= 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  PC stage presents a fetch address
req_addr  in  ADDR_W  byte address of the instruction
req_ready  out  1  fetch accepted this cycle when req_valid && req_ready
flush  in  1  discard all queued and in-flight fetches
imem_en  out  1  instruction memory read enable
imem_addr  out  ADDR_W  instruction memory byte address
imem_rdata  in  DATA_W  read data, valid one cycle after imem_en
inst_valid  out  1  head instruction available
inst_ready  in  1  IF/ID register accepts the head instruction
inst  out  DATA_W  instruction word
inst_pc  out  ADDR_W  PC of inst
inst_misalign  out  1  req_addr[1:0] != 0 for this entry

Behaviour:
- Reset (rst sampled high at posedge): queue count=0, rd/wr pointers=0, inflight=0. inst_valid=0, inst=0, inst_pc=0, inst_misalign=0. imem_en=0 while rst=1. rst has priority over flush and all handshakes.
- Credit rule: req_ready = !rst && !flush && (count + inflight) < DEPTH. Combinational, with no dependency on req_valid.
- Accept at cycle T (req_valid && req_ready):
  - Aligned address: imem_en=1 and imem_addr=req_addr in T.
  - Misaligned address: imem_en=0; the entry carries misalign=1 and inst=0 (NOP).
  - In both cases inflight<=1, and req_addr and the misalign flag are latched.
- Cycle T+1: imem_rdata (or 0 if misaligned) is written to the queue with the latched PC at the T+1 edge, and inflight clears unless a new accept occurs in T+1.
- Latency: accept in T gives inst_valid in T+2. Throughput is one fetch per cycle when inst_ready is held high.
- Output: inst_valid = (count != 0). inst, inst_pc and inst_misalign are the head entry, registered and stable while inst_valid && !inst_ready.
- Pop: inst_valid && inst_ready at posedge. A push and pop in the same cycle leave count unchanged.
- Full: the credit rule guarantees no overflow. A push into a full queue is a design error and must be flagged by an assertion.
- Pointers wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- Flush in cycle F:
  - count<=0, pointers<=0, inflight<=0.
  - The imem_rdata returned in F+1 from a read issued in F-1 is dropped.
  - req_ready=0 and imem_en=0 in F.
  - A pop in F is ignored.
  - inst_valid=0 from F+1 onward.
- Flush and rst asserted together: reset behaviour applies.
- Reset mid-operation: any in-flight read is dropped. The first fetch after reset is accepted in the first cycle with rst=0.

Decomposition:
- Package ifetch_pkg:
  - NOP_INST = 32'h0000_0000.
  - fetch_entry_t struct {inst, pc, misalign}.
  - Default widths.
- Sub-module sync_fifo (DEPTH, WIDTH): push/pop/count, with no bypass. Instantiated once, holding fetch_entry_t.
- Credit, inflight and flush logic stay in ifetch_responder.

Test Plan:
- Sequential stream: req_addr = 0x0, 0x4, 0x8 with imem returning 0x20080005, 0x20090003, 0x01095020 and inst_ready=1. Expect inst_valid from cycle 2 with inst/inst_pc pairs (0x20080005, 0x0), (0x20090003, 0x4), (0x01095020, 0x8) on consecutive cycles.
- Back-pressure: inst_ready=0 with req_valid held high. Expect exactly 4 accepts, then req_ready=0, and the head (inst_pc=0x0) held stable. Raising inst_ready drains in order 0x0, 0x4, 0x8, 0xC, and req_ready reasserts the cycle after the first pop.
- Flush with a read in flight: accept 0x10 in T and assert flush in T+1. Expect 0x10 never to appear, inst_valid=0 in T+2, and req_ready=0 in T+1. The next fetch 0x40 appears with inst_pc=0x40.
- Misaligned: req_addr=0x6. Expect imem_en=0, and an entry with inst=0, inst_pc=0x6, inst_misalign=1 two cycles later.
- Mid-operation reset: queue holding 3 entries, rst pulsed for 1 cycle. Expect inst_valid=0, inst=0, inst_pc=0 and req_ready=1 in the first cycle after rst deasserts.
- Simultaneous push and pop at count=DEPTH-1 with a continuous stream: expect count to stay at 3, no overflow assertion, and in-order delivery.
